// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FsBoot,
    FsRun,
    FsFault
  } fetch_state_e;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Fetch address priority mux (redirect > stall > sequential) and next-PC calculation.
module fetch_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic [31:0] pc_q,
  input  logic [31:0] pc_if,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_q_next,
  output logic [31:0] pc_if_next
);

  always_comb begin
    imem_addr  = pc_q;
    pc_if_next = pc_q;
    pc_q_next  = pc_q + PC_STEP;
    if (redirect_valid) begin
      imem_addr  = redirect_pc;
      pc_if_next = redirect_pc;
      pc_q_next  = redirect_pc + PC_STEP;
    end else if (stall) begin
      // Re-read the current word so imem_rdata stays stable while held.
      imem_addr  = pc_if;
      pc_if_next = pc_if;
      pc_q_next  = pc_q;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives synchronous-read imem, handles
// stall, redirect with wrong-path squash, and a sticky misaligned-target fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc1,
  output logic        fetch_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_if_q, pc_if_d;
  logic         if_v_q, if_v_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q;
  logic [31:0]  addr_q;

  logic [31:0]  sel_addr, pc_q_next, pc_if_next;

  fetch_pc_sel u_pc_sel (
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .pc_q           (pc_q),
    .pc_if          (pc_if_q),
    .imem_addr      (sel_addr),
    .pc_q_next      (pc_q_next),
    .pc_if_next     (pc_if_next)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_if_d     = pc_if_q;
    if_v_d      = if_v_q;
    fault_d     = fault_q;
    imem_addr   = sel_addr;
    ir          = NOP_INSN;
    pc1         = pc_if_q;
    fetch_valid = 1'b0;
    case (state_q)
      FsBoot: begin
        imem_addr = RESET_PC;
        pc_if_d   = RESET_PC;
        pc_d      = RESET_PC + PC_STEP;
        if_v_d    = 1'b1;
        state_d   = FsRun;
      end
      FsRun: begin
        // The instruction on imem_rdata during a redirect is wrong-path: squash it.
        fetch_valid = if_v_q & ~redirect_valid;
        ir          = fetch_valid ? imem_rdata : NOP_INSN;
        if (redirect_valid && misaligned(redirect_pc)) begin
          fault_d = 1'b1;
          if_v_d  = 1'b0;
          state_d = FsFault;
        end else begin
          pc_d    = pc_q_next;
          pc_if_d = pc_if_next;
          if (redirect_valid) begin
            if_v_d = 1'b1;
          end
        end
      end
      FsFault: begin
        imem_addr = addr_q;
      end
      default: begin
        state_d = FsBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FsBoot;
      pc_q    <= RESET_PC + PC_STEP;
      pc_if_q <= RESET_PC;
      if_v_q  <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_if_q <= pc_if_d;
      if_v_q  <= if_v_d;
      fault_q <= fault_d;
      addr_q  <= imem_addr;
      if (fetch_valid && !stall) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. Owns the program counter and drives a synchronous-read instruction memory. Presents `ir`/`pc1` to the decoder, which registers them on every `clk` edge. Handles pipeline stall, branch/jump redirect with wrong-path squash, and misaligned-target fault.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold the current instruction.
- `redirect_valid`  in  1  taken branch/JAL/JALR resolved this cycle.
- `redirect_pc`  in  32  target byte address.
- `imem_addr`  out  32  byte address to instruction memory; memory returns the word one cycle later.
- `imem_rdata`  in  32  instruction word for the address sampled at the previous edge.
- `ir`  out  32  instruction to decoder.
- `pc1`  out  32  address of `ir`.
- `fetch_valid`  out  1  `ir` is a real fetched instruction, not an injected NOP.
- `fault`  out  1  sticky misaligned-redirect flag.
- `fetch_count`  out  32  number of instructions handed off.

## Operation
- NOP is `ADDI x0,x0,0` = 32'h0000_0013.
- Registers:
  - `pc_q`: next sequential address.
  - `pc_if`: address whose data is on `imem_rdata`.
  - `if_v`: `imem_rdata` is meaningful.
  - `state`.
- States:
  - BOOT: after reset. Drive `imem_addr=RESET_PC`, output NOP. At the edge: `pc_if<=RESET_PC`, `pc_q<=RESET_PC+4`, `if_v<=1`, go to RUN.
  - RUN: normal sequencing.
  - FAULT: terminal until `rst`. `imem_addr` holds its last value; outputs NOP, `fetch_valid=0`.
- Outputs in RUN:
  - `ir = if_v ? imem_rdata : NOP`
  - `pc1 = pc_if`
  - `fetch_valid = if_v & ~redirect_valid`
- `imem_addr` select, priority high to low:
  - `redirect_valid`: `redirect_pc`.
  - `stall`: `pc_if` (re-read, so `imem_rdata` stays stable).
  - else: `pc_q`.
- Edge update in RUN:
  - Redirect with `redirect_pc[1:0]==0`: `pc_if<=redirect_pc`, `pc_q<=redirect_pc+4`, `if_v<=1`. During the redirect cycle `ir` is forced to NOP (squashes the wrong-path instruction).
  - Redirect with `redirect_pc[1:0]!=0`: `fault<=1`, `if_v<=0`, go to FAULT.
  - Stall, no redirect: registers unchanged.
  - Neither: `pc_if<=pc_q`, `pc_q<=pc_q+4`.
- Redirect beats stall when both are asserted.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0, with no flag.
- `fetch_count` increments by 1 on edges where `fetch_valid & ~stall`. It wraps at 2^32.

## Timing
- Reset values (applied asynchronously):
  - `pc_q=RESET_PC+4`, `pc_if=RESET_PC`, `if_v=0`, state BOOT.
  - `imem_addr=RESET_PC`, `ir=NOP`, `pc1=RESET_PC`.
  - `fetch_valid=0`, `fault=0`, `fetch_count=0`.
- Reset asserted mid-operation: outputs take their reset values immediately, without waiting for an edge.
- Fetch latency: the first valid `ir` appears one cycle after reset release (BOOT→RUN).
- Redirect penalty:
  - The cycle with `redirect_valid` outputs a NOP.
  - The target instruction appears on `ir` in the next cycle.
  - The instruction already captured by the decoder is squashed downstream, not here.
- Stall:
  - `ir`/`pc1` are identical on every stalled cycle; the decoder re-decodes the same instruction.
  - On the first unstalled cycle the same instruction is still presented. The next sequential instruction appears the cycle after.

## Structure
- `NOP_INSN` and the state encodings (`FS_BOOT`, `FS_RUN`, `FS_FAULT`) go in `99_define.v` next to the existing opcode/ALU defines.
- One natural sub-module: `fetch_pc_sel`, purely combinational. It computes the priority `imem_addr` mux and the next `pc_q`/`pc_if`. State, registers and counter stay in `fetch_unit`.

## Test plan
- Reset release with memory word[i] = 32'h00000093 + (i<<20): after the BOOT cycle, `pc1` shows 0, 4, 8, 12 on consecutive cycles with the matching words. `fetch_count` reaches 4 after 4 RUN cycles.
- Stall held 3 cycles while `pc1=8`: `ir`/`pc1` stay at 8 for 4 cycles (3 stalled + 1 release). `pc1=12` follows. `fetch_count` does not advance during the stall.
- `redirect_valid` with `redirect_pc=32'h100` while `pc1=8`: that cycle `ir=NOP` and `fetch_valid=0`. Next cycle `pc1=32'h100`, then 32'h104.
- `redirect_valid` and `stall` in the same cycle, `redirect_pc=32'h40`: the redirect is taken, and next `pc1=32'h40`.
- `redirect_pc=32'h102`: `fault=1` from the next cycle. `ir` stays NOP for 10+ cycles. Only `rst` clears it and restarts at `RESET_PC`.
- Asynchronous `rst` pulse between edges while `pc1=32'h20`: outputs go to their reset values before the next edge. With `RESET_PC=32'hFFFF_FFFC`, `pc1` sequence is FFFF_FFFC, 0, 4.
